ioctl_sdram_reader: RTL
=======================

// Module: ioctl_sdram_reader
// PURPOSE
//  HPS upload path: services ioctl_upload byte reads by fetching from SDRAM channel ch0 and returning ioctl_din.
//  It is the read-side counterpart of the ioctl download/write path, and sits between hps_io and the sdram controller.
//  It keeps a one-byte prefetch of addr+1 so sequential uploads avoid an SDRAM round-trip.
//  It drives the controller's refresh request whenever no SDRAM access is pending.
// PARAMETERS
//  BASE_ADDR    25'h0000000  SDRAM byte address mapped to ioctl_addr 0
//  UPLOAD_SIZE  27'd768      valid upload length; ioctl_addr >= UPLOAD_SIZE reads 8'hFF without SDRAM access
//  PREFETCH     1            1 = speculative read of last_addr+1; 0 = no prefetch
// PORTS
//  clk_sys       in   1   system clock; all logic on posedge
//  reset         in   1   synchronous, active-high
//  ioctl_upload  in   1   upload session active (level)
//  ioctl_rd      in   1   one-cycle read strobe from HPS
//  ioctl_addr    in   27  byte address of the request, valid with ioctl_rd
//  ioctl_din     out  8   read data; valid when ioctl_wait is low after a strobe
//  ioctl_wait    out  1   high while a requested byte is not yet available
//  ch_addr       out  25  SDRAM byte address
//  ch_rd         out  1   one-cycle read pulse to sdram ch0
//  ch_busy       in   1   sdram ch0 busy
//  ch_dout       in   8   sdram ch0 read data; valid when busy falls
//  refresh       out  1   refresh request to sdram controller
// BEHAVIOUR
//  Reset values: ioctl_din=8'h00, ioctl_wait=0, ch_rd=0, ch_addr=BASE_ADDR, refresh=1, state=IDLE, pf_valid=0.
//  Reset mid-access: forced to IDLE at once. A read already in flight in SDRAM completes and its data is discarded.
//  States:
//  - IDLE: refresh=1. Accepts a strobe.
//  - ISSUE: ch_rd=1 for exactly one cycle; ch_addr stable from ISSUE through WAIT.
//  - ARM: one cycle; ch_busy ignored (covers controller busy-rise latency).
//  - WAIT: hold until ch_busy=0, then latch ch_dout.
//  - PF_ISSUE, PF_ARM, PF_WAIT: prefetch copies of ISSUE, ARM and WAIT.
//  refresh=0 in every state except IDLE.
//  Strobe in IDLE (ioctl_upload=1, ioctl_rd=1, address A); in priority order:
//  - A >= UPLOAD_SIZE: ioctl_din<=8'hFF next cycle; ioctl_wait stays 0; pf_valid unchanged.
//  - pf_valid && A==pf_addr (hit): ioctl_din<=pf_data next cycle; ioctl_wait stays 0; then PF_ISSUE for A+1.
//  - miss: ioctl_wait<=1 next cycle; ch_addr<=BASE_ADDR+A[24:0]; go to ISSUE.
//  Miss completion: in the WAIT cycle where ch_busy=0, ioctl_din<=ch_dout and ioctl_wait<=0, both effective next cycle.
//  - Then PF_ISSUE for A+1 if PREFETCH=1 and A+1<UPLOAD_SIZE; otherwise IDLE.
//  Miss latency: ioctl_wait high for 3+N cycles, where N = cycles ch_busy stays high after ARM.
//  Prefetch completion: pf_data<=ch_dout, pf_addr<=A+1, pf_valid<=1; go to IDLE.
//  Strobe while a prefetch is in flight:
//  - ioctl_wait<=1 next cycle; the request is captured in a 1-entry pending register.
//  - On prefetch completion: if pending addr==pf_addr, serve from pf_data (ioctl_wait<=0) and chain the next prefetch; else go to ISSUE for the pending addr.
//  A strobe while ioctl_wait=1 from a miss is a protocol violation; it is ignored.
//  ioctl_upload low: pf_valid<=0 and pending is cleared. An in-flight access finishes, then IDLE. ioctl_rd is ignored.
//  Address arithmetic: ch_addr = BASE_ADDR + ioctl_addr[24:0], mod 2^25 (wraps silently). The A+1 compare uses the full 27 bits.
//  ch_rd is never high in two consecutive cycles and never high while ch_busy=1 in ISSUE (ISSUE waits for !ch_busy).
// TESTING
//  - Reset, then single ioctl_rd at A=5 with SDRAM[5]=8'h3C and busy held for 4 cycles.
//    -> ch_rd pulses once with ch_addr=BASE+5; ioctl_wait high for 7 cycles; ioctl_din=8'h3C; then a prefetch of addr 6.
//  - Sequential rd at 0,1,2,3 spaced 20 cycles apart, SDRAM = 8'h10,11,12,13.
//    -> addr 0 misses; addrs 1..3 hit with ioctl_wait never asserted; ioctl_din=8'h11,8'h12,8'h13.
//  - rd A=9 after a prefetch of 1 completes -> miss; pf stays addr 1 until overwritten by the prefetch of 10; data correct.
//  - rd A=800 (>= UPLOAD_SIZE) -> ioctl_din=8'hFF, no ch_rd pulse, ioctl_wait stays 0.
//  - rd A=1 one cycle into the prefetch of 1 -> ioctl_wait high until the prefetch completes, then ioctl_din=SDRAM[1]; no second ch_rd for addr 1.
//  - reset asserted during WAIT, busy falls later -> ioctl_wait=0 and refresh=1 the cycle after reset; late ch_dout is not latched into ioctl_din.

Source files
------------

// File: rtl/ioctl_sdram_reader_if.sv
// Bus bundle between hps_io upload side, the reader and sdram ch0.
// slave = the reader; master = the surrounding system.
interface ioctl_sdram_reader_if;
  logic        ioctl_upload;
  logic        ioctl_rd;
  logic [26:0] ioctl_addr;
  logic [7:0]  ioctl_din;
  logic        ioctl_wait;
  logic [24:0] ch_addr;
  logic        ch_rd;
  logic        ch_busy;
  logic [7:0]  ch_dout;
  logic        refresh;

  modport slave (
    input  ioctl_upload,
    input  ioctl_rd,
    input  ioctl_addr,
    output ioctl_din,
    output ioctl_wait,
    output ch_addr,
    output ch_rd,
    input  ch_busy,
    input  ch_dout,
    output refresh
  );

  modport master (
    output ioctl_upload,
    output ioctl_rd,
    output ioctl_addr,
    input  ioctl_din,
    input  ioctl_wait,
    input  ch_addr,
    input  ch_rd,
    output ch_busy,
    output ch_dout,
    input  refresh
  );
endinterface

// File: rtl/ioctl_sdram_reader.sv
// HPS upload reader: byte reads from SDRAM ch0 with a one-byte
// sequential prefetch; refresh is requested whenever idle.
module ioctl_sdram_reader #(
  parameter logic [24:0] BASE_ADDR   = 25'h0000000,
  parameter logic [26:0] UPLOAD_SIZE = 27'd768,
  parameter bit          PREFETCH    = 1'b1
) (
  input logic                  clk_sys,
  input logic                  reset,
  ioctl_sdram_reader_if.slave  io
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] ISSUE    = 3'd1;
  localparam logic [2:0] ARM      = 3'd2;
  localparam logic [2:0] WAIT     = 3'd3;
  localparam logic [2:0] PF_ISSUE = 3'd4;
  localparam logic [2:0] PF_ARM   = 3'd5;
  localparam logic [2:0] PF_WAIT  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [7:0]  din_q, din_d;
  logic        wait_q, wait_d;
  logic [24:0] ch_addr_q, ch_addr_d;
  logic [26:0] req_q, req_d;
  logic        pf_valid_q, pf_valid_d;
  logic [26:0] pf_addr_q, pf_addr_d;
  logic [7:0]  pf_data_q, pf_data_d;
  logic        pend_q, pend_d;
  logic [26:0] pend_addr_q, pend_addr_d;

  logic        strobe;
  logic        pv;
  logic [26:0] pa;
  logic [26:0] a_nxt, req_nxt, pa_nxt;

  function automatic logic [24:0] map(input logic [24:0] a);
    return BASE_ADDR + a;
  endfunction

  assign strobe  = io.ioctl_upload && io.ioctl_rd;
  assign a_nxt   = io.ioctl_addr + 27'd1;
  assign req_nxt = req_q + 27'd1;
  // A strobe landing in the completing cycle counts as pending
  assign pv      = io.ioctl_upload && (pend_q || strobe);
  assign pa      = pend_q ? pend_addr_q : io.ioctl_addr;
  assign pa_nxt  = pa + 27'd1;

  always_comb begin
    state_d     = state_q;
    din_d       = din_q;
    wait_d      = wait_q;
    ch_addr_d   = ch_addr_q;
    req_d       = req_q;
    pf_valid_d  = pf_valid_q;
    pf_addr_d   = pf_addr_q;
    pf_data_d   = pf_data_q;
    pend_d      = pend_q;
    pend_addr_d = pend_addr_q;
    case (state_q)
      IDLE: begin
        if (strobe) begin
          if (io.ioctl_addr >= UPLOAD_SIZE) begin
            din_d = 8'hFF;
          end else if (pf_valid_q
                       && io.ioctl_addr == pf_addr_q) begin
            din_d = pf_data_q;
            if (PREFETCH && a_nxt < UPLOAD_SIZE) begin
              req_d     = a_nxt;
              ch_addr_d = map(a_nxt[24:0]);
              state_d   = PF_ISSUE;
            end
          end else begin
            wait_d    = 1'b1;
            req_d     = io.ioctl_addr;
            ch_addr_d = map(io.ioctl_addr[24:0]);
            state_d   = ISSUE;
          end
        end
      end
      ISSUE: if (!io.ch_busy) state_d = ARM;
      ARM:   state_d = WAIT;
      WAIT: begin
        if (!io.ch_busy) begin
          din_d  = io.ch_dout;
          wait_d = 1'b0;
          if (PREFETCH && io.ioctl_upload
              && req_nxt < UPLOAD_SIZE) begin
            req_d     = req_nxt;
            ch_addr_d = map(req_nxt[24:0]);
            state_d   = PF_ISSUE;
          end else begin
            state_d = IDLE;
          end
        end
      end
      PF_ISSUE, PF_ARM, PF_WAIT: begin
        if (strobe && !pend_q) begin
          pend_d      = 1'b1;
          pend_addr_d = io.ioctl_addr;
          wait_d      = 1'b1;
        end
        if (state_q == PF_ISSUE && !io.ch_busy)
          state_d = PF_ARM;
        if (state_q == PF_ARM)
          state_d = PF_WAIT;
        if (state_q == PF_WAIT && !io.ch_busy) begin
          pf_data_d  = io.ch_dout;
          pf_addr_d  = req_q;
          pf_valid_d = 1'b1;
          state_d    = IDLE;
          if (pv) begin
            pend_d = 1'b0;
            if (pa >= UPLOAD_SIZE) begin
              din_d  = 8'hFF;
              wait_d = 1'b0;
            end else if (pa == req_q) begin
              din_d  = io.ch_dout;
              wait_d = 1'b0;
              if (pa_nxt < UPLOAD_SIZE) begin
                req_d     = pa_nxt;
                ch_addr_d = map(pa_nxt[24:0]);
                state_d   = PF_ISSUE;
              end
            end else begin
              wait_d    = 1'b1;
              req_d     = pa;
              ch_addr_d = map(pa[24:0]);
              state_d   = ISSUE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (!io.ioctl_upload) begin
      pf_valid_d = 1'b0;
      pend_d     = 1'b0;
      if (pend_q) wait_d = 1'b0;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q     <= IDLE;
      din_q       <= 8'h00;
      wait_q      <= 1'b0;
      ch_addr_q   <= BASE_ADDR;
      req_q       <= '0;
      pf_valid_q  <= 1'b0;
      pf_addr_q   <= '0;
      pf_data_q   <= 8'h00;
      pend_q      <= 1'b0;
      pend_addr_q <= '0;
    end else begin
      state_q     <= state_d;
      din_q       <= din_d;
      wait_q      <= wait_d;
      ch_addr_q   <= ch_addr_d;
      req_q       <= req_d;
      pf_valid_q  <= pf_valid_d;
      pf_addr_q   <= pf_addr_d;
      pf_data_q   <= pf_data_d;
      pend_q      <= pend_d;
      pend_addr_q <= pend_addr_d;
    end
  end

  assign io.ioctl_din  = din_q;
  assign io.ioctl_wait = wait_q;
  assign io.ch_addr    = ch_addr_q;
  assign io.ch_rd      = (state_q == ISSUE || state_q == PF_ISSUE)
                         && !io.ch_busy;
  assign io.refresh    = (state_q == IDLE);
endmodule
